// File: rtl/stack_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of a 5-entry structural stack.
// Tracks occupancy, rejects illegal requests, and drives the stack one operation at a time.
module stack_arbiter #(
   parameter int DEPTH = 5,
   parameter int DW    = 4,
   parameter int IW    = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          req0_i,
   input  logic          req1_i,
   input  logic [1:0]    cmd0_i,
   input  logic [1:0]    cmd1_i,
   input  logic [IW-1:0] idx0_i,
   input  logic [IW-1:0] idx1_i,
   input  logic [DW-1:0] wdata0_i,
   input  logic [DW-1:0] wdata1_i,
   output logic          gnt0_o,
   output logic          gnt1_o,
   output logic          done0_o,
   output logic          done1_o,
   output logic          err_o,
   output logic [DW-1:0] rdata_o,
   output logic [IW-1:0] count_o,
   output logic          st_reset_o,
   output logic [1:0]    st_command_o,
   output logic [IW-1:0] st_index_o,
   output logic [DW-1:0] st_wdata_o,
   output logic          st_we_o,
   input  logic [DW-1:0] st_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_e;

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;
   localparam logic [1:0] CMD_GET  = 2'b11;

   state_e        state_q, state_d;
   logic [1:0]    cmd_q, cmd_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          owner_q, owner_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          last_q, last_d;
   logic          err_q, err_d;
   logic [IW-1:0] count_q, count_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          win;
   logic [1:0]    win_cmd;
   logic [IW-1:0] win_idx;
   logic [DW-1:0] win_wdata;
   logic          illegal;

   // Tie goes to the client that did not win last; a lone requester always wins.
   always_comb begin
      win       = req1_i & (~req0_i | ~last_q);
      win_cmd   = win ? cmd1_i   : cmd0_i;
      win_idx   = win ? idx1_i   : idx0_i;
      win_wdata = win ? wdata1_i : wdata0_i;
      illegal   = ((win_cmd == CMD_PUSH) && (count_q == IW'(DEPTH))) ||
                  ((win_cmd == CMD_POP)  && (count_q == '0)) ||
                  ((win_cmd == CMD_GET)  && (win_idx >= count_q));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cmd_q   <= CMD_NOP;
         idx_q   <= '0;
         wdata_q <= '0;
         owner_q <= 1'b0;
         gnt_q   <= '0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         count_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         err_q   <= err_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      err_d   = err_q;
      count_d = count_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req0_i || req1_i) begin
               cmd_d   = win_cmd;
               idx_d   = win_idx;
               wdata_d = win_wdata;
               owner_d = win;
               gnt_d   = win ? 2'b10 : 2'b01;
               last_d  = win;
               err_d   = illegal;
               state_d = (illegal || (win_cmd == CMD_NOP)) ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cmd_q == CMD_PUSH) begin
               count_d = count_q + IW'(1);
               state_d = S_RESP;
            end else begin
               if (cmd_q == CMD_POP) count_d = count_q - IW'(1);
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            rdata_d = st_rdata_i;
            state_d = S_RESP;
         end
         S_RESP: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stack bus carries the latched request only during ISSUE; zero otherwise.
   always_comb begin
      st_command_o = CMD_NOP;
      st_index_o   = '0;
      st_wdata_o   = '0;
      st_we_o      = 1'b0;
      done0_o      = 1'b0;
      done1_o      = 1'b0;
      err_o        = 1'b0;
      if (state_q == S_ISSUE) begin
         st_command_o = cmd_q;
         st_index_o   = idx_q;
         st_wdata_o   = wdata_q;
         st_we_o      = (cmd_q == CMD_PUSH);
      end
      if (state_q == S_RESP) begin
         done0_o = ~owner_q;
         done1_o = owner_q;
         err_o   = err_q;
      end
   end

   assign gnt0_o     = gnt_q[0];
   assign gnt1_o     = gnt_q[1];
   assign rdata_o    = rdata_q;
   assign count_o    = count_q;
   assign st_reset_o = ~rst_ni;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: a queue-based stack model predicts each granted
// transaction, and a negedge monitor compares every DONE and the stack bus.
module tb_stack_arbiter;
   localparam int DEPTH = 5;
   localparam int DW    = 4;
   localparam int IW    = 3;
   localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req;
   logic [1:0]    cmd [2];
   logic [IW-1:0] idx [2];
   logic [DW-1:0] wd  [2];
   logic          gnt0, gnt1, done0, done1, err, st_reset, st_we;
   logic [DW-1:0] rdata, st_wdata, st_rdata;
   logic [IW-1:0] count, st_index;
   logic [1:0]    st_command;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   stack_arbiter #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_i(req[0]), .req1_i(req[1]),
      .cmd0_i(cmd[0]), .cmd1_i(cmd[1]),
      .idx0_i(idx[0]), .idx1_i(idx[1]),
      .wdata0_i(wd[0]), .wdata1_i(wd[1]),
      .gnt0_o(gnt0), .gnt1_o(gnt1),
      .done0_o(done0), .done1_o(done1),
      .err_o(err), .rdata_o(rdata), .count_o(count),
      .st_reset_o(st_reset), .st_command_o(st_command),
      .st_index_o(st_index), .st_wdata_o(st_wdata), .st_we_o(st_we),
      .st_rdata_i(st_rdata)
   );

   // Behavioural 5-entry stack the arbiter drives (entry 0 is the top).
   logic [DW-1:0] stk [DEPTH];
   always @(posedge clk) begin
      if (st_reset) begin
         for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
         st_rdata <= '0;
      end else begin
         case (st_command)
            PUSH: begin
               stk[0] <= st_wdata;
               for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
            end
            POP: begin
               st_rdata <= stk[0];
               for (int i = 0; i < DEPTH-1; i++) stk[i] <= stk[i+1];
               stk[DEPTH-1] <= '0;
            end
            GET: st_rdata <= (int'(st_index) < DEPTH) ? stk[int'(st_index)] : '0;
            default: ;
         endcase
      end
   end

   // Reference model
   typedef struct { int client; bit err; int rdata; int count; int cyc; } exp_t;
   exp_t sb[$];
   int   mq[$];
   int   last_w  = 1;
   int   last_rd = 0;
   int   issue_cyc = -1;
   logic [1:0]    issue_cmd;
   logic [IW-1:0] issue_idx;
   logic [DW-1:0] issue_wd;
   logic [1:0]    prev_gnt;

   logic [1:0]    s_req;
   logic [1:0]    s_cmd [2];
   logic [IW-1:0] s_idx [2];
   logic [DW-1:0] s_wd  [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      mq.delete();
      last_w  = 1;
      last_rd = 0;
   endtask

   task automatic grant_event();
      int w;
      int ix;
      int lat;
      bit bad;
      logic [1:0] c;
      exp_t e;
      w = (s_req[0] && s_req[1]) ? 1 - last_w : (s_req[1] ? 1 : 0);
      check("grant_winner", {30'd0, gnt1, gnt0}, (w == 1) ? 32'd2 : 32'd1);
      last_w = w;
      c   = s_cmd[w];
      ix  = int'(s_idx[w]);
      bad = 1'b0;
      lat = 1;
      case (c)
         PUSH: if (mq.size() == DEPTH) bad = 1'b1;
               else begin mq.push_front(int'(s_wd[w])); lat = 2; end
         POP:  if (mq.size() == 0) bad = 1'b1;
               else begin last_rd = mq.pop_front(); lat = 3; end
         GET:  if (ix >= mq.size()) bad = 1'b1;
               else begin last_rd = mq[ix]; lat = 3; end
         default: ;
      endcase
      issue_cyc = (lat > 1) ? cyc : -1;
      issue_cmd = c;
      issue_idx = s_idx[w];
      issue_wd  = s_wd[w];
      e.client = w;
      e.err    = bad;
      e.rdata  = last_rd;
      e.count  = mq.size();
      e.cyc    = cyc + lat - 1;
      sb.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      s_req = req;
      for (int i = 0; i < 2; i++) begin
         s_cmd[i] = cmd[i];
         s_idx[i] = idx[i];
         s_wd[i]  = wd[i];
      end
   end

   // Monitor: grant prediction, stack bus, and DONE scoreboard
   initial begin
      exp_t e;
      prev_gnt = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_gnt  = '0;
            issue_cyc = -1;
         end else begin
            if ({gnt1, gnt0} != 2'b00 && prev_gnt == 2'b00) grant_event();
            prev_gnt = {gnt1, gnt0};
            if (cyc == issue_cyc)
               check("st_bus_issue", {22'd0, st_command, st_index, st_wdata, st_we},
                     {22'd0, issue_cmd, issue_idx, issue_wd, issue_cmd == PUSH});
            else
               check("st_bus_quiet", {22'd0, st_command, st_index, st_wdata, st_we}, 32'd0);
            if (done0 || done1) begin
               check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done at cycle %0d: got done0=%0b done1=%0b expected none", cyc, done0, done1);
               end else begin
                  e = sb.pop_front();
                  check("done_client", done1 ? 32'd1 : 32'd0, e.client);
                  check("done_cycle", cyc, e.cyc);
                  check("err", {31'd0, err}, {31'd0, e.err});
                  check("rdata", {28'd0, rdata}, e.rdata);
                  check("count", {29'd0, count}, e.count);
               end
            end
         end
      end
   end

   task automatic op(input int c, input logic [1:0] cm, input int ix, input int d);
      bit got;
      got = 1'b0;
      cmd[c] = cm;
      idx[c] = IW'(ix);
      wd[c]  = DW'(d);
      req[c] = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if ((c == 0) ? done0 : done1) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL op_timeout client %0d: got no DONE in 40 cycles, expected one", c);
      end
      req[c] = 1'b0;
   endtask

   task automatic hold(input int c, input logic [1:0] cm, input int ix, input int d, input int n);
      int seen;
      seen = 0;
      cmd[c] = cm;
      idx[c] = IW'(ix);
      wd[c]  = DW'(d);
      req[c] = 1'b1;
      for (int k = 0; k < n * 12 && seen < n; k++) begin
         @(negedge clk);
         if ((c == 0) ? done0 : done1) seen++;
      end
      check("hold_dones", seen, n);
      req[c] = 1'b0;
   endtask

   task automatic wait_gnt0();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (gnt0) got = 1'b1;
      end
      check("gnt0_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic check_reset_outputs();
      check("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
      check("rst_done",  {30'd0, done1, done0}, 32'd0);
      check("rst_err",   {31'd0, err}, 32'd0);
      check("rst_rdata", {28'd0, rdata}, 32'd0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_stbus", {22'd0, st_command, st_index, st_wdata, st_we}, 32'd0);
      check("rst_streset", {31'd0, st_reset}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      #1 check_reset_outputs();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      rst_n = 1'b0;
      req   = '0;
      for (int i = 0; i < 2; i++) begin
         cmd[i] = NOP;
         idx[i] = '0;
         wd[i]  = '0;
      end
      repeat (3) @(negedge clk);
      #1 check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill, overflow, read back by index, then drain and underflow
      for (int i = 1; i <= 6; i++) op(0, PUSH, 0, i);
      for (int i = 0; i <= 5; i++) op(1, GET, i, 0);
      for (int i = 0; i < 6; i++) op(0, POP, 0, 0);
      op(1, NOP, 0, 0);

      // Both clients requesting continuously from reset
      do_reset();
      fork
         hold(0, PUSH, 0, 9, 4);
         hold(1, GET, 0, 0, 4);
      join

      // Reset during CAPTURE of a POP with three entries
      do_reset();
      for (int i = 0; i < 3; i++) op(0, PUSH, 0, 7 + i);
      cmd[0] = POP;
      req[0] = 1'b1;
      wait_gnt0();
      @(negedge clk);
      rst_n  = 1'b0;
      req[0] = 1'b0;
      #1 check_reset_outputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("count_after_abort", {29'd0, count}, 32'd0);
      op(0, POP, 0, 0);

      // Requester drops REQ during ISSUE of its PUSH
      cmd[0] = PUSH;
      wd[0]  = 4'd3;
      req[0] = 1'b1;
      wait_gnt0();
      req[0] = 1'b0;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done0) pulses++;
      end
      check("dropped_req_done_pulses", pulses, 1);

      // Randomized contention
      fork
         for (int n = 0; n < 30; n++) begin
            op(0, 2'($urandom_range(0, 3)), $urandom_range(0, 5), $urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         for (int n = 0; n < 30; n++) begin
            op(1, 2'($urandom_range(0, 3)), $urandom_range(0, 5), $urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      join

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000 time units, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Two-requester arbiter and sequencer for the 5-entry, 4-bit structural stack. It accepts NOP/PUSH/POP/GET requests from two independent clients and grants them round-robin. It tracks occupancy and rejects illegal operations before they reach the stack. It drives the stack's COMMAND/INDEX/data bus one operation at a time and returns read data to the granted client with a DONE pulse.

## Interface
- DEPTH, 5, stack entries; legal occupancy 0..DEPTH
- DW, 4, data width
- IW, 3, index width
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- REQ0 / REQ1  in  1  request from client 0 / 1; level, held until DONEx
- CMD0 / CMD1  in  2  00 NOP, 01 PUSH, 10 POP, 11 GET; stable while REQx high
- IDX0 / IDX1  in  IW  GET index; 0 = top of stack
- WDATA0 / WDATA1  in  DW  PUSH data
- GNT0 / GNT1  out  1  registered; high while that client owns the stack
- DONE0 / DONE1  out  1  one-cycle completion pulse
- ERR  out  1  qualifies DONEx: 1 = request rejected, stack untouched
- RDATA  out  DW  registered read data; valid in the DONE cycle of a POP/GET
- COUNT  out  IW  current occupancy
- ST_RESET  out  1  active-high reset to the stack; equals ~RESET (combinational)
- ST_COMMAND  out  2  command to the stack
- ST_INDEX  out  IW  index to the stack
- ST_WDATA  out  DW  write data to the stack
- ST_WE  out  1  1 = controller drives the shared data bus (PUSH only)
- ST_RDATA  in  DW  stack data output

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - ST_COMMAND = NOP, ST_WE = 0.
  - If any REQ is high, pick the winner. With one request, that client wins. With two, the client != LAST wins.
  - Latch the winner's CMD/IDX/WDATA, set its GNT, and set LAST = winner.
- Legality check on the latched request, in IDLE:
  - PUSH with COUNT == DEPTH → illegal.
  - POP with COUNT == 0 → illegal.
  - GET with IDX >= COUNT → illegal.
  - Illegal requests go to RESP with ERR = 1.
  - NOP is legal and goes to RESP with ERR = 0.
  - All other requests go to ISSUE.
- ISSUE (one cycle):
  - Drive ST_COMMAND = cmd, ST_INDEX = idx, ST_WDATA = wdata; ST_WE = 1 for PUSH only.
  - At the end of the cycle: COUNT += 1 for PUSH, COUNT -= 1 for POP.
  - PUSH → RESP; POP/GET → CAPTURE.
- CAPTURE (one cycle):
  - ST_COMMAND = NOP.
  - At the end of the cycle, register ST_RDATA into RDATA.
  - → RESP.
- RESP (one cycle):
  - DONEx = 1 for the owner; ERR as decided in IDLE.
  - At the end of the cycle: GNTx clears, state → IDLE.
- RDATA holds its value until the next CAPTURE. After PUSH, NOP or an error, RDATA keeps its previous value.
- REQx still high in the IDLE following DONEx counts as a new request.
- Deasserting REQx mid-transaction is ignored; the transaction completes.
- COUNT never leaves 0..DEPTH.
- ST_INDEX and ST_WDATA are 0 outside ISSUE.

## Timing
- Reset (RESET low, asynchronous):
  - State = IDLE; COUNT, RDATA, GNTx, DONEx, ERR, ST_COMMAND, ST_INDEX, ST_WDATA, ST_WE all 0.
  - LAST = 1, so client 0 wins the first tie.
  - ST_RESET = 1, keeping stack contents consistent with COUNT = 0.
- Reset mid-transaction: abort immediately. No DONE, no COUNT update.
- Reset deassertion is taken at the next rising edge.
- Edge E0 is the edge at which IDLE sees REQx high:
  - PUSH: ISSUE in cycle E0..E1; DONE in cycle E1..E2. Latency 2 cycles.
  - POP/GET: ISSUE E0..E1, CAPTURE E1..E2, DONE E2..E3. Latency 3 cycles.
  - Error or NOP: DONE in E0..E1. Latency 1 cycle.
- The stack samples ST_COMMAND at the end of ISSUE. ST_RDATA is required to be stable by the end of CAPTURE.
- Minimum spacing between back-to-back grants is 1 IDLE cycle. Throughput is at most one operation per 3 (PUSH) or 4 (POP/GET) cycles.

## Test plan
- Reset, then client 0 issues PUSH with data 1..5:
  - Each push gets DONE0 two cycles after request, ERR = 0; COUNT steps 1..5.
  - A 6th PUSH gets DONE0 with ERR = 1 one cycle after request; COUNT stays 5 and ST_COMMAND stays NOP.
- With stack [5,4,3,2,1] (top first), client 1 issues GET with IDX 0..4:
  - RDATA = 5,4,3,2,1, each three cycles after request.
  - GET with IDX = 5 → ERR = 1.
- POP ×5 from the full stack:
  - RDATA = 5,4,3,2,1; COUNT goes down to 0.
  - A 6th POP → ERR = 1, COUNT stays 0.
- Both REQ held high continuously, client 0 PUSH and client 1 GET IDX 0, starting from reset:
  - Grants alternate 0,1,0,1.
  - Client 1's GETs return the latest pushed value.
  - DONE0 and DONE1 are never high in the same cycle.
- RESET pulsed low during the CAPTURE of a POP with COUNT = 3:
  - All outputs are 0 immediately; no DONE is issued.
  - COUNT = 0 after release.
  - A following POP → ERR = 1.
- Client 0 drops REQ0 one cycle after the PUSH grant: the PUSH still completes and DONE0 pulses once.
